pipe_mem_wb_skid: RTL and testbench
===================================

# pipe_mem_wb_skid

Parametrised MEM/WB pipeline stage with a valid/ready handshake and a two-entry skid buffer, so the write-back side can stall without a combinational ready path back into MEM. It sits between the MEM stage and the register-file write port. It adds a registered write-back result mux, a forwarding tap and a bubble counter, and keeps NOP-on-flush semantics: every field zero, `reg_write` = 0.

## Interface
Parameters:
- `DATA_W`, 16: width of ALU result, memory data and write-back data.
- `RD_W`, 4: destination register index width.
- `R0_ZERO`, 1: when 1, register 0 is hardwired; writes to rd=0 are never forwarded.
- `CNT_W`, 16: bubble counter width.

Ports (clock and reset):
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.

Ports (control and MEM side):
- `flush` in 1: synchronous; discards both entries.
- `in_valid` in 1: MEM presents a transfer.
- `in_ready` out 1: stage can accept; registered.
- `mem_to_reg_in` in 1: write-back source select.
- `reg_write_in` in 1: register write enable.
- `alu_result_in` in DATA_W: ALU result.
- `mem_data_in` in DATA_W: load data.
- `rd_in` in RD_W: destination index.

Ports (WB side):
- `out_valid` out 1: output entry holds a transfer.
- `out_ready` in 1: WB consumes the transfer.
- `mem_to_reg`, `reg_write`, `alu_result`, `mem_data`, `rd` out: output entry fields.
- `wb_data` out DATA_W: `mem_to_reg ? mem_data : alu_result`.
- `fwd_valid` out 1: `out_valid & reg_write & (!R0_ZERO | rd != 0)`.
- `fwd_rd` out RD_W: equals `rd`.
- `fwd_data` out DATA_W: equals `wb_data`.
- `bubble_cnt` out CNT_W: saturating count of starved cycles.

## Operation
- Storage and signals:
  - Entries: MAIN drives the outputs; SKID is internal.
  - accept = `in_valid & in_ready`.
  - pop = `out_valid & out_ready`.
- State EMPTY (`out_valid` = 0, `in_ready` = 1):
  - accept → MAIN loaded, go to ONE.
  - Otherwise stay in EMPTY.
- State ONE (`out_valid` = 1, `in_ready` = 1):
  - accept & pop → MAIN reloaded with the input, stay in ONE.
  - accept & !pop → SKID loaded, go to TWO.
  - !accept & pop → MAIN zeroed, go to EMPTY.
  - Otherwise hold.
- State TWO (`out_valid` = 1, `in_ready` = 0):
  - pop → MAIN ← SKID, SKID zeroed, go to ONE.
  - Otherwise hold.
  - `in_valid` is ignored; MEM must hold its data.
- Ordering: strictly FIFO. No transfer is dropped or duplicated except on flush.
- While `out_valid` = 0, all MAIN payload fields are zero, so `reg_write` = 0 (NOP).
- Flush:
  - Next state EMPTY; both entries zeroed; `in_ready` = 1.
  - Flush dominates a simultaneous accept or pop: the input is discarded, and the pop completes only from WB's point of view.
- `bubble_cnt`:
  - Increments when `out_ready & !out_valid`.
  - Saturates at all-ones; does not wrap.
  - Unaffected by flush; cleared only by rst.
- `wb_data` and the forwarding outputs are combinational from MAIN only; SKID is never forwarded.

## Timing
- Reset: asynchronous.
  - State EMPTY; `in_ready` = 1; `out_valid` = 0.
  - All payload, `wb_data`, `fwd_*` = 0.
  - `bubble_cnt` = 0.
- Latency: accept at edge N → `out_valid` and fields visible after edge N.
- Throughput: one transfer per cycle while `out_ready` = 1.
- `in_ready` changes only on clock edges. There is no combinational path from `out_ready` to `in_ready`.
- `in_ready` deasserts the cycle after a second entry is captured and reasserts the cycle after the pop out of TWO.
- Reset asserted mid-transfer clears everything immediately. The first accept is possible on the first edge after rst deasserts.

## Test plan
- **Reset:** drive rst mid-stream with entries in TWO → immediately `out_valid` = 0, `in_ready` = 1, `rd` = 0, `bubble_cnt` = 0.
- **Streaming:** `out_ready` held 1, 4 back-to-back transfers with rd = 1..4 and alu = 0x0011..0x0044 → outputs appear 1 cycle later in order, `in_ready` never drops.
- **Backpressure:**
  - Stimulus: `out_ready` = 0 while 2 transfers are sent (rd = 5, then rd = 6); hold `in_valid` with rd = 7.
  - Required: `in_ready` = 0 after the 2nd accept.
  - Then raise `out_ready` → outputs rd = 5, 6, 7 in order with no loss.
- **Write-back mux and forwarding:**
  - `mem_to_reg` = 1, mem = 0xBEEF, alu = 0x1234, rd = 3, `reg_write` = 1 → `wb_data` = 0xBEEF, `fwd_valid` = 1.
  - Repeat with rd = 0 and `R0_ZERO` = 1 → `fwd_valid` = 0.
- **Flush:** from TWO, assert flush together with `in_valid` → next cycle `out_valid` = 0, `reg_write` = 0, `in_ready` = 1; the flushed input never appears.
- **Bubble counter:** with `CNT_W` = 4, hold `out_ready` = 1 and `in_valid` = 0 for 20 cycles → `bubble_cnt` = 15, saturated, with no wrap.

Source files
------------

// File: rtl/pipe_mem_wb_skid_if.sv
// Bundle of every MEM -> stage -> WB signal of pipe_mem_wb_skid.
//   master : the surrounding pipeline (drives MEM payload, flush, out_ready)
//   slave  : the MEM/WB stage itself (drives in_ready, WB payload, fwd, bubble_cnt)
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high; valid must stay asserted with a stable payload until ready is
// seen, and ready never depends combinationally on valid.
interface pipe_mem_wb_skid_if #(
  parameter int DATA_W = 16,
  parameter int RD_W   = 4,
  parameter int CNT_W  = 16
);
  logic              flush;
  // MEM side
  logic              in_valid;
  logic              in_ready;
  logic              mem_to_reg_in;
  logic              reg_write_in;
  logic [DATA_W-1:0] alu_result_in;
  logic [DATA_W-1:0] mem_data_in;
  logic [RD_W-1:0]   rd_in;
  // WB side
  logic              out_valid;
  logic              out_ready;
  logic              mem_to_reg;
  logic              reg_write;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] mem_data;
  logic [RD_W-1:0]   rd;
  logic [DATA_W-1:0] wb_data;
  // forwarding tap and statistics
  logic              fwd_valid;
  logic [RD_W-1:0]   fwd_rd;
  logic [DATA_W-1:0] fwd_data;
  logic [CNT_W-1:0]  bubble_cnt;

  modport master (
    output flush, in_valid, mem_to_reg_in, reg_write_in, alu_result_in,
           mem_data_in, rd_in, out_ready,
    input  in_ready, out_valid, mem_to_reg, reg_write, alu_result, mem_data,
           rd, wb_data, fwd_valid, fwd_rd, fwd_data, bubble_cnt
  );

  modport slave (
    input  flush, in_valid, mem_to_reg_in, reg_write_in, alu_result_in,
           mem_data_in, rd_in, out_ready,
    output in_ready, out_valid, mem_to_reg, reg_write, alu_result, mem_data,
           rd, wb_data, fwd_valid, fwd_rd, fwd_data, bubble_cnt
  );
endinterface

// File: rtl/pipe_mem_wb_skid.sv
// MEM/WB pipeline stage with a two-entry skid buffer (MAIN + SKID).
// MAIN drives the WB outputs; SKID absorbs one extra transfer so in_ready can
// be a plain register with no combinational path from out_ready.
// Ports:
//   clk, rst   : rising-edge clock, asynchronous active-high reset
//   bus        : pipe_mem_wb_skid_if.slave (handshakes, payloads, flush,
//                wb_data, forwarding tap, bubble_cnt)
//   dbg_state  : current FSM state (0 EMPTY, 1 ONE, 2 TWO)
// Interface parameters DATA_W/RD_W/CNT_W must match the module parameters.
module pipe_mem_wb_skid #(
  parameter int DATA_W  = 16,
  parameter int RD_W    = 4,
  parameter int R0_ZERO = 1,
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  pipe_mem_wb_skid_if.slave      bus,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic              mem_to_reg;
    logic              reg_write;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] mem_data;
    logic [RD_W-1:0]   rd;
  } payload_t;

  state_t           state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  payload_t         main_q;
  payload_t         skid_q;
  payload_t         in_p;
  logic [CNT_W-1:0] bubble_q;
  logic             accept;
  logic             pop;

  assign in_p   = {bus.mem_to_reg_in, bus.reg_write_in, bus.alu_result_in,
                   bus.mem_data_in, bus.rd_in};
  assign accept = bus.in_valid & in_ready_q;
  assign pop    = out_valid_q & bus.out_ready;

  // Single FSM; in_ready and out_valid are registered alongside the state.
  // Any entry that is not holding a transfer is kept all-zero so MAIN is a
  // NOP (reg_write = 0) whenever out_valid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      main_q      <= '0;
      skid_q      <= '0;
    end else if (bus.flush) begin
      // Flush wins over a same-cycle accept (input dropped) and pop.
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      main_q      <= '0;
      skid_q      <= '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_q      <= in_p;
            out_valid_q <= 1'b1;
            state_q     <= ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_q <= in_p;
          end else if (accept) begin
            skid_q     <= in_p;
            in_ready_q <= 1'b0;
            state_q    <= TWO;
          end else if (pop) begin
            main_q      <= '0;
            out_valid_q <= 1'b0;
            state_q     <= EMPTY;
          end
        end
        TWO: begin
          // in_ready is low here, so MEM is holding; only a pop moves us.
          if (pop) begin
            main_q     <= skid_q;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
            state_q    <= ONE;
          end
        end
        default: begin
          state_q     <= EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          main_q      <= '0;
          skid_q      <= '0;
        end
      endcase
    end
  end

  // Starved-cycle counter: WB was ready but had nothing. Saturates, and
  // flush deliberately leaves it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_q <= '0;
    end else if (bus.out_ready && !out_valid_q && (bubble_q != '1)) begin
      bubble_q <= bubble_q + 1'b1;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.mem_to_reg = main_q.mem_to_reg;
  assign bus.reg_write  = main_q.reg_write;
  assign bus.alu_result = main_q.alu_result;
  assign bus.mem_data   = main_q.mem_data;
  assign bus.rd         = main_q.rd;
  assign bus.bubble_cnt = bubble_q;
  assign dbg_state      = state_q;

  // Write-back mux and forwarding tap look at MAIN only; SKID is invisible.
  assign bus.wb_data   = main_q.mem_to_reg ? main_q.mem_data : main_q.alu_result;
  assign bus.fwd_rd    = main_q.rd;
  assign bus.fwd_data  = bus.wb_data;
  assign bus.fwd_valid = out_valid_q & main_q.reg_write &
                         ((R0_ZERO == 0) || (main_q.rd != '0));

endmodule

// File: tb/tb_pipe_mem_wb_skid.sv
// Self-checking bench for pipe_mem_wb_skid: per-scenario tasks plus a
// negedge scoreboard that pushes on accept and pops/compares on pop.
module tb_pipe_mem_wb_skid;
  localparam int DATA_W = 16;
  localparam int RD_W   = 4;
  localparam int CNT_W  = 4;
  localparam int W      = 1 + 1 + DATA_W + DATA_W + RD_W + DATA_W + 1 + RD_W + DATA_W;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  pipe_mem_wb_skid_if #(.DATA_W(DATA_W), .RD_W(RD_W), .CNT_W(CNT_W)) bus ();

  pipe_mem_wb_skid #(.DATA_W(DATA_W), .RD_W(RD_W), .R0_ZERO(1), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired, required finish before 200000");
    $fatal(1, "watchdog");
  end

  // expected output vector of one transfer, from first principles
  function automatic logic [W-1:0] pack_exp(input logic m2r, input logic rw,
      input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] mem,
      input logic [RD_W-1:0] rd);
    logic [DATA_W-1:0] wb;
    logic fv;
    wb = m2r ? mem : alu;
    fv = rw && (rd != 0);
    return {m2r, rw, alu, mem, rd, wb, fv, rd, wb};
  endfunction

  // scoreboard
  always @(negedge clk) begin
    logic [W-1:0] got;
    logic [W-1:0] exp;
    if (rst) begin
      exp_q.delete();
    end else begin
      got = {bus.mem_to_reg, bus.reg_write, bus.alu_result, bus.mem_data, bus.rd,
             bus.wb_data, bus.fwd_valid, bus.fwd_rd, bus.fwd_data};
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got %h, required no output", got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL sb_data: got %h, required %h", got, exp);
          end
        end
      end
      if (!bus.out_valid) begin
        checks++;
        if ({bus.reg_write, bus.rd, bus.wb_data, bus.fwd_valid} !== '0) begin
          errors++;
          $display("FAIL sb_nop: reg_write=%b rd=%h wb=%h fwd_valid=%b, required all 0",
                   bus.reg_write, bus.rd, bus.wb_data, bus.fwd_valid);
        end
      end
      if (bus.flush) exp_q.delete();
      else if (bus.in_valid && bus.in_ready)
        exp_q.push_back(pack_exp(bus.mem_to_reg_in, bus.reg_write_in,
                                 bus.alu_result_in, bus.mem_data_in, bus.rd_in));
    end
  end

  // driver tasks (enter and leave #1 after a rising edge)
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic m2r, input logic rw, input logic [DATA_W-1:0] alu,
                      input logic [DATA_W-1:0] mem, input logic [RD_W-1:0] rd);
    logic acc;
    int n;
    bus.in_valid      = 1'b1;
    bus.mem_to_reg_in = m2r;
    bus.reg_write_in  = rw;
    bus.alu_result_in = alu;
    bus.mem_data_in   = mem;
    bus.rd_in         = rd;
    n = 0;
    do begin
      acc = bus.in_ready;
      tick();
      n++;
    end while (!acc && n < 50);
    if (!acc) begin
      errors++;
      $display("FAIL send_timeout: in_ready=0 after %0d cycles, required 1", n);
    end
  endtask

  task automatic idle();
    bus.in_valid      = 1'b0;
    bus.mem_to_reg_in = 1'b0;
    bus.reg_write_in  = 1'b0;
    bus.alu_result_in = '0;
    bus.mem_data_in   = '0;
    bus.rd_in         = '0;
  endtask

  task automatic drain();
    int n;
    idle();
    bus.out_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain: pending=%0d out_valid=%b, required 0 and 0",
               exp_q.size(), bus.out_valid);
    end
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if ({bus.out_valid, bus.in_ready, bus.rd, bus.wb_data, bus.fwd_valid, bus.bubble_cnt, dbg_state}
        !== {1'b0, 1'b1, {RD_W{1'b0}}, {DATA_W{1'b0}}, 1'b0, {CNT_W{1'b0}}, 2'd0}) begin
      errors++;
      $display("FAIL reset_state: out_valid=%b in_ready=%b rd=%h wb=%h bubble=%0d state=%0d, required 0 1 0 0 0 0",
               bus.out_valid, bus.in_ready, bus.rd, bus.wb_data, bus.bubble_cnt, dbg_state);
    end
  endtask

  task automatic test_bubble();
    bus.out_ready = 1'b1;
    repeat (5) tick();
    checks++;
    if (bus.bubble_cnt !== 4'd5) begin
      errors++;
      $display("FAIL bubble_5: got %0d, required 5", bus.bubble_cnt);
    end
    repeat (10) tick();
    checks++;
    if (bus.bubble_cnt !== 4'd15) begin
      errors++;
      $display("FAIL bubble_15: got %0d, required 15", bus.bubble_cnt);
    end
    repeat (5) tick();
    checks++;
    if (bus.bubble_cnt !== 4'd15) begin
      errors++;
      $display("FAIL bubble_sat: got %0d, required 15", bus.bubble_cnt);
    end
  endtask

  task automatic test_streaming();
    logic [DATA_W-1:0] alu;
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream_in_ready: beat %0d got %b, required 1", i, bus.in_ready);
      end
      alu = DATA_W'(i * 16'h0011);
      send(1'b0, 1'b1, alu, DATA_W'($urandom_range(0, 16'hffff)), RD_W'(i));
      checks++;
      if (bus.out_valid !== 1'b1 || bus.rd !== RD_W'(i) || bus.wb_data !== alu) begin
        errors++;
        $display("FAIL stream_latency: out_valid=%b rd=%h wb=%h, required 1 %h %h",
                 bus.out_valid, bus.rd, bus.wb_data, RD_W'(i), alu);
      end
    end
    drain();
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    send(1'b0, 1'b1, 16'h0505, 16'h5050, 4'd5);
    send(1'b1, 1'b1, 16'h0606, 16'h6060, 4'd6);
    checks++;
    if (bus.in_ready !== 1'b0 || dbg_state !== 2'd2) begin
      errors++;
      $display("FAIL bp_full: in_ready=%b state=%0d, required 0 2", bus.in_ready, dbg_state);
    end
    bus.in_valid      = 1'b1;
    bus.mem_to_reg_in = 1'b0;
    bus.reg_write_in  = 1'b1;
    bus.alu_result_in = 16'h0707;
    bus.mem_data_in   = 16'h7070;
    bus.rd_in         = 4'd7;
    repeat (3) tick();
    checks++;
    if (bus.in_ready !== 1'b0 || bus.rd !== 4'd5) begin
      errors++;
      $display("FAIL bp_hold: in_ready=%b rd=%h, required 0 5", bus.in_ready, bus.rd);
    end
    bus.out_ready = 1'b1;
    send(1'b0, 1'b1, 16'h0707, 16'h7070, 4'd7);
    drain();
  endtask

  task automatic test_wb_fwd();
    bus.out_ready = 1'b0;
    send(1'b1, 1'b1, 16'h1234, 16'hBEEF, 4'd3);
    send(1'b1, 1'b1, 16'h1234, 16'hBEEF, 4'd0);
    idle();
    checks++;
    if ({bus.wb_data, bus.fwd_valid, bus.fwd_rd, bus.fwd_data} !== {16'hBEEF, 1'b1, 4'd3, 16'hBEEF}) begin
      errors++;
      $display("FAIL fwd_rd3: wb=%h fwd_valid=%b fwd_rd=%h fwd_data=%h, required beef 1 3 beef",
               bus.wb_data, bus.fwd_valid, bus.fwd_rd, bus.fwd_data);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checks++;
    if ({bus.out_valid, bus.reg_write, bus.wb_data, bus.fwd_valid} !== {1'b1, 1'b1, 16'hBEEF, 1'b0}) begin
      errors++;
      $display("FAIL fwd_rd0: out_valid=%b reg_write=%b wb=%h fwd_valid=%b, required 1 1 beef 0",
               bus.out_valid, bus.reg_write, bus.wb_data, bus.fwd_valid);
    end
    drain();
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    send(1'b0, 1'b1, 16'h0909, 16'h9090, 4'd9);
    send(1'b0, 1'b1, 16'h0a0a, 16'ha0a0, 4'd10);
    bus.in_valid      = 1'b1;
    bus.reg_write_in  = 1'b1;
    bus.alu_result_in = 16'h0b0b;
    bus.rd_in         = 4'd11;
    bus.flush         = 1'b1;
    tick();
    bus.flush = 1'b0;
    idle();
    checks++;
    if ({bus.out_valid, bus.reg_write, bus.in_ready, bus.rd, bus.alu_result, bus.mem_data}
        !== {1'b0, 1'b0, 1'b1, {RD_W{1'b0}}, {DATA_W{1'b0}}, {DATA_W{1'b0}}}) begin
      errors++;
      $display("FAIL flush: out_valid=%b reg_write=%b in_ready=%b rd=%h alu=%h mem=%h, required 0 0 1 0 0 0",
               bus.out_valid, bus.reg_write, bus.in_ready, bus.rd, bus.alu_result, bus.mem_data);
    end
    bus.out_ready = 1'b1;
    repeat (4) tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_ghost: out_valid=%b, required 0", bus.out_valid);
    end
    drain();
  endtask

  task automatic test_reset_midstream();
    bus.out_ready = 1'b0;
    send(1'b0, 1'b1, 16'h0c0c, 16'hc0c0, 4'd12);
    send(1'b0, 1'b1, 16'h0d0d, 16'hd0d0, 4'd13);
    idle();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.out_valid, bus.in_ready, bus.rd, bus.bubble_cnt, dbg_state}
        !== {1'b0, 1'b1, {RD_W{1'b0}}, {CNT_W{1'b0}}, 2'd0}) begin
      errors++;
      $display("FAIL reset_mid: out_valid=%b in_ready=%b rd=%h bubble=%0d state=%0d, required 0 1 0 0 0",
               bus.out_valid, bus.in_ready, bus.rd, bus.bubble_cnt, dbg_state);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    bus.out_ready = 1'b1;
    send(1'b1, 1'b1, 16'h0e0e, 16'he0e0, 4'd14);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.rd !== 4'd14 || bus.wb_data !== 16'he0e0) begin
      errors++;
      $display("FAIL reset_first_accept: out_valid=%b rd=%h wb=%h, required 1 e e0e0",
               bus.out_valid, bus.rd, bus.wb_data);
    end
    drain();
  endtask

  initial begin
    rst = 1'b1;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    idle();
    test_reset();
    test_bubble();
    test_streaming();
    test_backpressure();
    test_wb_fwd();
    test_flush();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
